// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline: datapath widths,
// ALU operation encodings, the hard-wired zero register and the
// all-zero control word used when a bubble is loaded into a stage.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } aluop_e;

    // Single-bit stage controls travelling with an instruction.
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: flags when the load sitting in
// EX writes a register the instruction in ID actually reads. Loads to the
// zero register never create a dependency.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    output logic              load_use_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs_i && (ex_rd_i == id_rs_i);
    assign rt_hit = id_uses_rt_i && (ex_rd_i == id_rt_i);

    assign load_use_o = ex_valid_i && ex_memread_i && (ex_rd_i != '0) &&
                        id_valid_i && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, stall freeze,
// branch squash (remembered across a stall) and WB->ID write-through.
// Optional bubble_cnt performance counter enabled by ID_EX_PERF_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_memtoreg,
    input  logic               id_alusrc,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               wb_regwrite,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               id_ex_valid,
    output logic [DATA_W-1:0]  id_ex_pc,
    output logic [DATA_W-1:0]  id_ex_rs_data,
    output logic [DATA_W-1:0]  id_ex_rt_data,
    output logic [DATA_W-1:0]  id_ex_imm,
    output logic [REG_AW-1:0]  id_ex_rs,
    output logic [REG_AW-1:0]  id_ex_rt,
    output logic [REG_AW-1:0]  id_ex_rd,
    output logic               id_ex_regwrite,
    output logic               id_ex_memread,
    output logic               id_ex_memwrite,
    output logic               id_ex_memtoreg,
    output logic               id_ex_alusrc,
    output logic [ALUOP_W-1:0] id_ex_aluop,
    output logic               hold_upstream
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]        bubble_cnt
`endif
);

    import mips_pkg::*;

    logic               valid_q,   valid_d;
    logic [DATA_W-1:0]  pc_q,      pc_d;
    logic [DATA_W-1:0]  rs_data_q, rs_data_d;
    logic [DATA_W-1:0]  rt_data_q, rt_data_d;
    logic [DATA_W-1:0]  imm_q,     imm_d;
    logic [REG_AW-1:0]  rs_q,      rs_d;
    logic [REG_AW-1:0]  rt_q,      rt_d;
    logic [REG_AW-1:0]  rd_q,      rd_d;
    ctrl_t              ctrl_q,    ctrl_d;
    logic [ALUOP_W-1:0] aluop_q,   aluop_d;
    logic               pending_flush_q, pending_flush_d;

    logic  load_use;
    logic  kill;
    logic  wb_hit_rs;
    logic  wb_hit_rt;
    ctrl_t id_ctrl;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid_i   (valid_q),
        .ex_memread_i (ctrl_q.memread),
        .ex_rd_i      (rd_q),
        .id_valid_i   (id_valid),
        .id_uses_rs_i (id_uses_rs),
        .id_uses_rt_i (id_uses_rt),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .load_use_o   (load_use)
    );

    // A flush seen while stalled is remembered so the squash still happens.
    assign kill = flush_in || pending_flush_q;

    assign hold_upstream = stall_in || (!kill && load_use);

    // Register-file bypass for a write retiring in the same cycle.
    assign wb_hit_rs = wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == id_rs);
    assign wb_hit_rt = wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == id_rt);

    assign id_ctrl = '{regwrite: id_regwrite, memread: id_memread,
                       memwrite: id_memwrite, memtoreg: id_memtoreg,
                       alusrc: id_alusrc};

    // Next-state selection: stall hold, squash/load-use bubble, or capture.
    always_comb begin
        valid_d         = valid_q;
        pc_d            = pc_q;
        rs_data_d       = rs_data_q;
        rt_data_d       = rt_data_q;
        imm_d           = imm_q;
        rs_d            = rs_q;
        rt_d            = rt_q;
        rd_d            = rd_q;
        ctrl_d          = ctrl_q;
        aluop_d         = aluop_q;
        pending_flush_d = pending_flush_q;

        if (stall_in) begin
            if (flush_in) begin
                pending_flush_d = 1'b1;
            end
        end else if (kill || load_use) begin
            // Zero indices keep the forwarding unit from matching a bubble.
            valid_d   = 1'b0;
            pc_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = REG_ZERO;
            rt_d      = REG_ZERO;
            rd_d      = REG_ZERO;
            ctrl_d    = CTRL_BUBBLE;
            aluop_d   = '0;
            if (kill) begin
                pending_flush_d = 1'b0;
            end
        end else begin
            valid_d   = id_valid;
            pc_d      = id_pc;
            rs_data_d = wb_hit_rs ? wb_data : id_rs_data;
            rt_data_d = wb_hit_rt ? wb_data : id_rt_data;
            imm_d     = id_imm;
            rs_d      = id_rs;
            rt_d      = id_rt;
            rd_d      = id_rd;
            ctrl_d    = id_valid ? id_ctrl : CTRL_BUBBLE;
            aluop_d   = id_valid ? id_aluop : '0;
        end
    end

    // Pipeline register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q         <= 1'b0;
            pc_q            <= '0;
            rs_data_q       <= '0;
            rt_data_q       <= '0;
            imm_q           <= '0;
            rs_q            <= '0;
            rt_q            <= '0;
            rd_q            <= '0;
            ctrl_q          <= CTRL_BUBBLE;
            aluop_q         <= '0;
            pending_flush_q <= 1'b0;
        end else begin
            valid_q         <= valid_d;
            pc_q            <= pc_d;
            rs_data_q       <= rs_data_d;
            rt_data_q       <= rt_data_d;
            imm_q           <= imm_d;
            rs_q            <= rs_d;
            rt_q            <= rt_d;
            rd_q            <= rd_d;
            ctrl_q          <= ctrl_d;
            aluop_q         <= aluop_d;
            pending_flush_q <= pending_flush_d;
        end
    end

    assign id_ex_valid    = valid_q;
    assign id_ex_pc       = pc_q;
    assign id_ex_rs_data  = rs_data_q;
    assign id_ex_rt_data  = rt_data_q;
    assign id_ex_imm      = imm_q;
    assign id_ex_rs       = rs_q;
    assign id_ex_rt       = rt_q;
    assign id_ex_rd       = rd_q;
    assign id_ex_regwrite = ctrl_q.regwrite;
    assign id_ex_memread  = ctrl_q.memread;
    assign id_ex_memwrite = ctrl_q.memwrite;
    assign id_ex_memtoreg = ctrl_q.memtoreg;
    assign id_ex_alusrc   = ctrl_q.alusrc;
    assign id_ex_aluop    = aluop_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Count load-use bubbles only; saturate rather than wrap.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!stall_in && !kill && load_use && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural reference model is
// compared against the DUT every falling edge, and directed scenarios pin
// the model with hand-computed values.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        stall_in, flush_in;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
    logic [3:0]  id_aluop;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_alusrc;
    logic [3:0]  id_ex_aluop;
    logic        hold_upstream;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    id_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_regwrite    (id_regwrite),
        .id_memread     (id_memread),
        .id_memwrite    (id_memwrite),
        .id_memtoreg    (id_memtoreg),
        .id_alusrc      (id_alusrc),
        .id_aluop       (id_aluop),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .id_ex_valid    (id_ex_valid),
        .id_ex_pc       (id_ex_pc),
        .id_ex_rs_data  (id_ex_rs_data),
        .id_ex_rt_data  (id_ex_rt_data),
        .id_ex_imm      (id_ex_imm),
        .id_ex_rs       (id_ex_rs),
        .id_ex_rt       (id_ex_rt),
        .id_ex_rd       (id_ex_rd),
        .id_ex_regwrite (id_ex_regwrite),
        .id_ex_memread  (id_ex_memread),
        .id_ex_memwrite (id_ex_memwrite),
        .id_ex_memtoreg (id_ex_memtoreg),
        .id_ex_alusrc   (id_ex_alusrc),
        .id_ex_aluop    (id_ex_aluop),
        .hold_upstream  (hold_upstream)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt     (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole EX-side view of one instruction slot.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic [3:0]  aluop;
    } slot_t;

    slot_t       m;          // what EX should currently see
    logic        m_pend;     // squash owed from a flush during a stall
    logic [31:0] m_cnt;      // expected load-use bubble count

    int n_tests;
    int n_fail;
    logic [31:0] pc_ctr;

    function automatic slot_t dut_view();
        return '{valid: id_ex_valid, pc: id_ex_pc, rs_data: id_ex_rs_data,
                 rt_data: id_ex_rt_data, imm: id_ex_imm, rs: id_ex_rs,
                 rt: id_ex_rt, rd: id_ex_rd, regwrite: id_ex_regwrite,
                 memread: id_ex_memread, memwrite: id_ex_memwrite,
                 memtoreg: id_ex_memtoreg, alusrc: id_ex_alusrc,
                 aluop: id_ex_aluop};
    endfunction

    // The ID instruction must wait if it reads what the EX load produces.
    function automatic logic ref_dependent(slot_t ex);
        logic reads_it;
        reads_it = (id_uses_rs && id_rs == ex.rd) || (id_uses_rt && id_rt == ex.rd);
        return ex.valid && ex.memread && (ex.rd != 5'd0) && id_valid && reads_it;
    endfunction

    // The slot EX receives when ID advances normally.
    function automatic slot_t ref_capture();
        slot_t s;
        s = '0;
        s.valid   = id_valid;
        s.pc      = id_pc;
        s.imm     = id_imm;
        s.rs      = id_rs;
        s.rt      = id_rt;
        s.rd      = id_rd;
        s.rs_data = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs) ? wb_data : id_rs_data;
        s.rt_data = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rt) ? wb_data : id_rt_data;
        if (id_valid) begin
            s.regwrite = id_regwrite;
            s.memread  = id_memread;
            s.memwrite = id_memwrite;
            s.memtoreg = id_memtoreg;
            s.alusrc   = id_alusrc;
            s.aluop    = id_aluop;
        end
        return s;
    endfunction

    function automatic logic ref_hold();
        if (stall_in) return 1'b1;
        if (flush_in || m_pend) return 1'b0;
        return ref_dependent(m);
    endfunction

    // Reference model advanced on each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m      <= '0;
            m_pend <= 1'b0;
            m_cnt  <= 32'd0;
        end else if (stall_in) begin
            if (flush_in) m_pend <= 1'b1;
        end else if (flush_in || m_pend) begin
            m      <= '0;
            m_pend <= 1'b0;
        end else if (ref_dependent(m)) begin
            m <= '0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
        end else begin
            m <= ref_capture();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall_in = 0; flush_in = 0; id_valid = 0; id_pc = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        id_alusrc = 0; id_aluop = 0;
        wb_regwrite = 0; wb_rd = 0; wb_data = 0;
    endtask

    // Present one instruction in ID: a load (lw) when ld=1, else an ALU op.
    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic urs, input logic urt,
                             input logic [31:0] rsd, input logic [31:0] rtd, input logic ld);
        pc_ctr      = pc_ctr + 32'd4;
        id_valid    = 1; id_pc = pc_ctr;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs  = urs; id_uses_rt = urt;
        id_rs_data  = rsd; id_rt_data = rtd;
        id_imm      = 32'h0000_0010 + pc_ctr;
        id_regwrite = 1; id_memread = ld; id_memwrite = 0;
        id_memtoreg = ld; id_alusrc = ld;
        id_aluop    = ld ? 4'd0 : 4'd2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        pc_ctr  = 32'h100;
        clear_in();
        rst = 1;

        // Every-cycle comparison of DUT against the reference model.
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    n_tests++;
                    if (dut_view() !== m) begin
                        n_fail++;
                        $display("FAIL model_regs t=%0t dut=%h model=%h", $time, dut_view(), m);
                    end
                    n_tests++;
                    if (hold_upstream !== ref_hold()) begin
                        n_fail++;
                        $display("FAIL model_hold t=%0t dut=%b model=%b", $time, hold_upstream, ref_hold());
                    end
`ifdef ID_EX_PERF_CNT_EN
                    n_tests++;
                    if (bubble_cnt !== m_cnt) begin
                        n_fail++;
                        $display("FAIL model_cnt t=%0t dut=%0d model=%0d", $time, bubble_cnt, m_cnt);
                    end
`endif
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, id_ex_valid}, 32'd0);
        chk("reset rd", {27'd0, id_ex_rd}, 32'd0);
        chk("reset pc", id_ex_pc, 32'd0);
        rst = 0;

        // Plain capture
        set_instr(5'd3, 5'd4, 5'd6, 1, 1, 32'h11, 32'h22, 0);
        #1 chk("plain hold", {31'd0, hold_upstream}, 32'd0);
        tick();
        chk("plain valid", {31'd0, id_ex_valid}, 32'd1);
        chk("plain rs", {27'd0, id_ex_rs}, 32'd3);
        chk("plain rs_data", id_ex_rs_data, 32'h11);
        chk("plain aluop", {28'd0, id_ex_aluop}, 32'd2);

        // Load-use: lw rd=5 then consumer of r5
        set_instr(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_instr(5'd5, 5'd2, 5'd7, 1, 1, 32'h55, 32'h66, 0);
        #1 chk("lu hold", {31'd0, hold_upstream}, 32'd1);
        tick();
        chk("lu bubble valid", {31'd0, id_ex_valid}, 32'd0);
        chk("lu bubble rd", {27'd0, id_ex_rd}, 32'd0);
        chk("lu hold drops", {31'd0, hold_upstream}, 32'd0);
        tick();
        chk("lu consumer valid", {31'd0, id_ex_valid}, 32'd1);
        chk("lu consumer rs", {27'd0, id_ex_rs}, 32'd5);

        // Load to $0 never stalls
        set_instr(5'd1, 5'd0, 5'd0, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_instr(5'd0, 5'd0, 5'd3, 1, 1, 32'h0, 32'h0, 0);
        #1 chk("r0 load hold", {31'd0, hold_upstream}, 32'd0);
        tick();
        chk("r0 load capture rd", {27'd0, id_ex_rd}, 32'd3);

        // Unused rt matching load destination does not stall
        set_instr(5'd1, 5'd0, 5'd6, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_instr(5'd2, 5'd6, 5'd4, 1, 0, 32'h0, 32'h0, 0);
        #1 chk("unused rt hold", {31'd0, hold_upstream}, 32'd0);
        tick();
        chk("unused rt capture", {27'd0, id_ex_rt}, 32'd6);

        // Write-through on rt, then wb_rd=0 keeps register data
        set_instr(5'd2, 5'd7, 5'd8, 1, 1, 32'h5, 32'h0, 0);
        wb_regwrite = 1; wb_rd = 5'd7; wb_data = 32'hABCD;
        tick();
        chk("wt rt_data", id_ex_rt_data, 32'hABCD);
        chk("wt rs_data", id_ex_rs_data, 32'h5);
        set_instr(5'd2, 5'd0, 5'd8, 1, 1, 32'h5, 32'h0, 0);
        wb_rd = 5'd0;
        tick();
        chk("wt r0 rt_data", id_ex_rt_data, 32'h0);
        wb_regwrite = 0;

        // Flush during a stall is applied on the first free edge
        set_instr(5'd9, 5'd10, 5'd11, 1, 1, 32'h9, 32'hA, 0);
        tick();
        stall_in = 1; flush_in = 1;
        set_instr(5'd12, 5'd13, 5'd14, 1, 1, 32'hC, 32'hD, 0);
        #1 chk("stall hold", {31'd0, hold_upstream}, 32'd1);
        tick();
        chk("stall frozen rd", {27'd0, id_ex_rd}, 32'd11);
        flush_in = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall frozen valid", {31'd0, id_ex_valid}, 32'd1);
        end
        stall_in = 0;
        #1 chk("pending flush hold", {31'd0, hold_upstream}, 32'd0);
        tick();
        chk("pending flush bubble", {31'd0, id_ex_valid}, 32'd0);
        tick();
        chk("after flush capture rd", {27'd0, id_ex_rd}, 32'd14);

        // Flush outranks load-use
        set_instr(5'd1, 5'd0, 5'd13, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_instr(5'd13, 5'd2, 5'd15, 1, 1, 32'h0, 32'h0, 0);
        flush_in = 1;
        #1 chk("flush over lu hold", {31'd0, hold_upstream}, 32'd0);
        tick();
        flush_in = 0;
        chk("flush bubble valid", {31'd0, id_ex_valid}, 32'd0);
        tick();
        chk("post flush rs", {27'd0, id_ex_rs}, 32'd13);

        // Back-to-back loads, one bubble per dependent consumer
        set_instr(5'd1, 5'd0, 5'd8, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_instr(5'd8, 5'd0, 5'd9, 1, 0, 32'h0, 32'h0, 1);
        #1 chk("b2b hold 1", {31'd0, hold_upstream}, 32'd1);
        tick();
        tick();
        chk("b2b lw2 rd", {27'd0, id_ex_rd}, 32'd9);
        set_instr(5'd9, 5'd3, 5'd10, 1, 1, 32'h0, 32'h0, 0);
        #1 chk("b2b hold 2", {31'd0, hold_upstream}, 32'd1);
        tick();
        tick();
        chk("b2b add rd", {27'd0, id_ex_rd}, 32'd10);

        // Stall while a load-use is pending holds the load
        set_instr(5'd1, 5'd0, 5'd14, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_instr(5'd2, 5'd14, 5'd3, 1, 1, 32'h0, 32'h0, 0);
        stall_in = 1;
        tick();
        chk("stall lu frozen rd", {27'd0, id_ex_rd}, 32'd14);
        stall_in = 0;
        tick();
        tick();
        chk("stall lu consumer rt", {27'd0, id_ex_rt}, 32'd14);

        // Invalid instruction: controls forced low, indices captured
        set_instr(5'd4, 5'd5, 5'd6, 1, 1, 32'h0, 32'h0, 1);
        id_valid = 0;
        tick();
        chk("invalid memread", {31'd0, id_ex_memread}, 32'd0);
        chk("invalid rd", {27'd0, id_ex_rd}, 32'd6);

        // Asynchronous reset mid-stream
        set_instr(5'd3, 5'd4, 5'd5, 1, 1, 32'h77, 32'h88, 0);
        tick();
        #2 rst = 1;
        #1;
        chk("async rst valid", {31'd0, id_ex_valid}, 32'd0);
        chk("async rst rs_data", id_ex_rs_data, 32'd0);
        chk("async rst regwrite", {31'd0, id_ex_regwrite}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("async rst bubble_cnt", bubble_cnt, 32'd0);
`endif
        rst = 0;
        set_instr(5'd1, 5'd0, 5'd5, 1, 0, 32'h0, 32'h0, 1);
        tick();
        set_instr(5'd5, 5'd0, 5'd2, 1, 0, 32'h0, 32'h0, 0);
        tick();
        chk("post rst lu bubble", {31'd0, id_ex_valid}, 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        chk("bubble_cnt one", bubble_cnt, 32'd1);
`endif
        tick();
        clear_in();
        tick();
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
